// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-requester arbiter in front of the cache-line AXI read bridge
// Define RD_ARB_RR_EN for round-robin arbitration; default is fixed priority, D over I.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_rd_req,
    input  logic [1:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_half,
    output logic [DATA_W-1:0] i_ret_data,
    input  logic              d_rd_req,
    input  logic [1:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic [DATA_W-1:0] d_ret_data,
    output logic              axi_rd_req,
    output logic [1:0]        axi_rd_type,
    output logic [ADDR_W-1:0] axi_rd_addr,
    input  logic              axi_rd_rdy,
    input  logic              axi_ret_valid,
    input  logic              axi_ret_half,
    input  logic [DATA_W-1:0] axi_ret_data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_WAIT = 3'b100
    } state_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;

    logic   winner;
    logic   owner_req;
    logic   fwd_en;
    logic   fwd_side;
    logic   accept;

    // Returns bypass all registering so the requester sees data on the bridge's beat.
    assign i_ret_data = axi_ret_data;
    assign d_ret_data = axi_ret_data;

    assign owner_req = (owner_q == SIDE_D) ? d_rd_req : i_rd_req;

`ifdef RD_ARB_RR_EN
    always_comb begin
        if (i_rd_req && d_rd_req) begin
            winner = ~last_grant_q;
        end else begin
            winner = d_rd_req ? SIDE_D : SIDE_I;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;

    always_comb begin
        winner = d_rd_req ? SIDE_D : SIDE_I;
    end
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        fwd_en       = 1'b0;
        fwd_side     = SIDE_I;
        i_ret_valid  = 1'b0;
        i_ret_half   = 1'b0;
        d_ret_valid  = 1'b0;

        // While in reset every control output stays low regardless of inputs.
        if (resetn) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_rd_req || d_rd_req) begin
                        fwd_en   = 1'b1;
                        fwd_side = winner;
                        owner_d  = winner;
                        state_d  = axi_rd_rdy ? ST_WAIT : ST_REQ;
                    end
                end
                ST_REQ: begin
                    fwd_side = owner_q;
                    if (owner_req) begin
                        fwd_en = 1'b1;
                        if (axi_rd_rdy) begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    i_ret_valid = axi_ret_valid && (owner_q == SIDE_I);
                    d_ret_valid = axi_ret_valid && (owner_q == SIDE_D);
                    // The data side never issues double-line reads, so its half strobe is dropped.
                    i_ret_half  = axi_ret_half && (owner_q == SIDE_I);
                    if (axi_ret_valid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        accept = fwd_en && axi_rd_rdy;
        if (accept) begin
            last_grant_d = fwd_side;
        end

        axi_rd_req  = fwd_en;
        axi_rd_type = fwd_en ? ((fwd_side == SIDE_D) ? d_rd_type : i_rd_type) : 2'b00;
        axi_rd_addr = fwd_en ? ((fwd_side == SIDE_D) ? d_rd_addr : i_rd_addr) : '0;
        i_rd_rdy    = accept && (fwd_side == SIDE_I);
        d_rd_rdy    = accept && (fwd_side == SIDE_D);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= SIDE_I;
            last_grant_q <= SIDE_I;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed scoreboard bench for axi_rd_arbiter
// Expectations for the both-request case follow RD_ARB_RR_EN when it is defined.
module tb_axi_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 512;

    logic              clk;
    logic              resetn;
    logic              i_rd_req;
    logic [1:0]        i_rd_type;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              i_rd_rdy;
    logic              i_ret_valid;
    logic              i_ret_half;
    logic [DATA_W-1:0] i_ret_data;
    logic              d_rd_req;
    logic [1:0]        d_rd_type;
    logic [ADDR_W-1:0] d_rd_addr;
    logic              d_rd_rdy;
    logic              d_ret_valid;
    logic [DATA_W-1:0] d_ret_data;
    logic              axi_rd_req;
    logic [1:0]        axi_rd_type;
    logic [ADDR_W-1:0] axi_rd_addr;
    logic              axi_rd_rdy;
    logic              axi_ret_valid;
    logic              axi_ret_half;
    logic [DATA_W-1:0] axi_ret_data;

    typedef struct packed {
        logic [1:0]        rdy;
        logic [1:0]        typ;
        logic [ADDR_W-1:0] addr;
    } acc_t;

    typedef struct packed {
        logic [2:0]        flags;
        logic [DATA_W-1:0] data;
    } ret_t;

    acc_t acc_q[$];
    ret_t ret_q[$];
    int   checks;
    int   errors;

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_half(i_ret_half),
        .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
        .axi_rd_req(axi_rd_req), .axi_rd_type(axi_rd_type), .axi_rd_addr(axi_rd_addr),
        .axi_rd_rdy(axi_rd_rdy), .axi_ret_valid(axi_ret_valid), .axi_ret_half(axi_ret_half),
        .axi_ret_data(axi_ret_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_i(input logic req, input logic [1:0] typ, input logic [ADDR_W-1:0] addr);
        i_rd_req = req; i_rd_type = typ; i_rd_addr = addr;
    endtask

    task automatic set_d(input logic req, input logic [1:0] typ, input logic [ADDR_W-1:0] addr);
        d_rd_req = req; d_rd_type = typ; d_rd_addr = addr;
    endtask

    task automatic set_b(input logic rdy, input logic rv, input logic rh, input logic [DATA_W-1:0] data);
        axi_rd_rdy = rdy; axi_ret_valid = rv; axi_ret_half = rh; axi_ret_data = data;
    endtask

    task automatic push_acc(input logic [1:0] rdy, input logic [1:0] typ, input logic [ADDR_W-1:0] addr);
        acc_t a;
        a.rdy = rdy; a.typ = typ; a.addr = addr;
        acc_q.push_back(a);
    endtask

    // flags = {i_ret_valid, i_ret_half, d_ret_valid}
    task automatic push_ret(input logic [2:0] flags, input logic [DATA_W-1:0] data);
        ret_t r;
        r.flags = flags; r.data = data;
        ret_q.push_back(r);
    endtask

    task automatic sample();
        acc_t ea;
        ret_t er;
        if (acc_q.size() > 0 || i_rd_rdy || d_rd_rdy) begin
            ea = '0;
            if (acc_q.size() > 0) ea = acc_q.pop_front();
            check("accept_rdy", {i_rd_rdy, d_rd_rdy}, ea.rdy);
            if (ea.rdy != 2'b00) begin
                check("accept_fwd", {axi_rd_req, axi_rd_type, axi_rd_addr}, {1'b1, ea.typ, ea.addr});
            end
        end
        if (ret_q.size() > 0 || i_ret_valid || i_ret_half || d_ret_valid) begin
            er = '0;
            if (ret_q.size() > 0) er = ret_q.pop_front();
            check("ret_flags", {i_ret_valid, i_ret_half, d_ret_valid}, er.flags);
            if (er.flags != 3'b000) begin
                check("ret_data", er.flags[0] ? d_ret_data : i_ret_data, er.data);
            end
        end
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic nxt();
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        mid();
        nxt();
    endtask

    localparam logic [DATA_W-1:0] DA = {16{32'ha5a5_0001}};
    localparam logic [DATA_W-1:0] DH = {16{32'h0000_ffff}};
    localparam logic [DATA_W-1:0] DB = {16{32'h1234_5678}};
    localparam logic [DATA_W-1:0] DC = {16{32'hdead_beef}};
    localparam logic [DATA_W-1:0] DE = {16{32'hcafe_f00d}};
    localparam logic [DATA_W-1:0] DG = {16{32'h5a5a_0002}};

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        set_i(1'b0, 2'd0, '0);
        set_d(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;

        // reset with every input active: no outputs
        set_i(1'b1, 2'd1, 32'h1fc0_0000);
        set_d(1'b1, 2'd1, 32'h8000_1000);
        set_b(1'b1, 1'b1, 1'b1, DA);
        mid();
        check("rst_axi_req", axi_rd_req, 1'b0);
        check("rst_axi_addr", axi_rd_addr, '0);
        nxt();
        cyc();
        resetn = 1'b1;
        set_i(1'b0, 2'd0, '0);
        set_d(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();

        // I only, single line, return at cycle 5
        set_i(1'b1, 2'd1, 32'h1fc0_0000);
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b10, 2'd1, 32'h1fc0_0000);
        mid();
        check("a_axi_req", axi_rd_req, 1'b1);
        nxt();
        for (int k = 1; k <= 4; k++) begin
            mid();
            check("a_wait_no_req", axi_rd_req, 1'b0);
            nxt();
        end
        set_b(1'b1, 1'b1, 1'b0, DA);
        push_ret(3'b100, DA);
        cyc();
        set_i(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();

        // I double line: half at cycle 4, final at cycle 8
        set_i(1'b1, 2'd2, 32'h1fc0_0040);
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b10, 2'd2, 32'h1fc0_0040);
        cyc();
        set_i(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 3; k++) cyc();
        set_b(1'b0, 1'b0, 1'b1, DH);
        push_ret(3'b010, DH);
        cyc();
        set_b(1'b0, 1'b0, 1'b0, '0);
        for (int k = 5; k <= 7; k++) cyc();
        set_b(1'b0, 1'b1, 1'b0, DB);
        push_ret(3'b100, DB);
        cyc();
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();

        // both request with last_grant = I: D first either way, I after one bubble
        set_i(1'b1, 2'd1, 32'h1fc0_0080);
        set_d(1'b1, 2'd1, 32'h8000_1000);
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b01, 2'd1, 32'h8000_1000);
        cyc();
        set_d(1'b0, 2'd0, '0);
        cyc();
        set_b(1'b1, 1'b1, 1'b0, DC);
        push_ret(3'b001, DC);
        cyc();
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b10, 2'd1, 32'h1fc0_0080);
        cyc();
        set_i(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();
        set_b(1'b0, 1'b1, 1'b0, DB);
        push_ret(3'b100, DB);
        cyc();
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();

        // D only, uncached; half strobe while D owns is dropped
        set_d(1'b1, 2'd0, 32'h8000_2000);
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b01, 2'd0, 32'h8000_2000);
        cyc();
        set_d(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b1, DH);
        cyc();
        set_b(1'b0, 1'b1, 1'b0, DE);
        push_ret(3'b001, DE);
        cyc();

        // both request with last_grant = D; I carries illegal type 3
        set_i(1'b1, 2'd3, 32'h1fc0_00c0);
        set_d(1'b1, 2'd1, 32'h8000_1040);
        set_b(1'b1, 1'b0, 1'b0, '0);
`ifdef RD_ARB_RR_EN
        push_acc(2'b10, 2'd3, 32'h1fc0_00c0);
        cyc();
        set_i(1'b0, 2'd0, '0);
        cyc();
        set_b(1'b1, 1'b1, 1'b0, DC);
        push_ret(3'b100, DC);
        cyc();
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b01, 2'd1, 32'h8000_1040);
        cyc();
        set_d(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();
        set_b(1'b0, 1'b1, 1'b0, DE);
        push_ret(3'b001, DE);
        cyc();
`else
        push_acc(2'b01, 2'd1, 32'h8000_1040);
        cyc();
        set_d(1'b0, 2'd0, '0);
        cyc();
        set_b(1'b1, 1'b1, 1'b0, DC);
        push_ret(3'b001, DC);
        cyc();
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b10, 2'd3, 32'h1fc0_00c0);
        cyc();
        set_i(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();
        set_b(1'b0, 1'b1, 1'b0, DE);
        push_ret(3'b100, DE);
        cyc();
`endif
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();

        // D stalled 3 cycles, I arrives mid-stall and must not preempt
        set_d(1'b1, 2'd1, 32'h8000_3000);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) set_i(1'b1, 2'd1, 32'h1fc0_0100);
            mid();
            check("e_stall_fwd", {axi_rd_req, axi_rd_addr}, {1'b1, 32'h8000_3000});
            nxt();
        end
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b01, 2'd1, 32'h8000_3000);
        cyc();
        set_d(1'b0, 2'd0, '0);
        cyc();
        set_b(1'b1, 1'b1, 1'b0, DG);
        push_ret(3'b001, DG);
        cyc();
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b10, 2'd1, 32'h1fc0_0100);
        cyc();
        set_i(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();
        set_b(1'b0, 1'b1, 1'b0, DA);
        push_ret(3'b100, DA);
        cyc();
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();

        // owner withdraws in REQ, then stray returns in IDLE are ignored
        set_i(1'b1, 2'd1, 32'h1fc0_0140);
        mid();
        check("f_req", axi_rd_req, 1'b1);
        nxt();
        set_i(1'b0, 2'd0, '0);
        mid();
        check("f_drop", axi_rd_req, 1'b0);
        nxt();
        set_b(1'b0, 1'b1, 1'b1, DC);
        cyc();
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();

        // reset during WAIT discards the outstanding return
        set_i(1'b1, 2'd1, 32'h1fc0_0180);
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b10, 2'd1, 32'h1fc0_0180);
        cyc();
        set_i(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0);
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        set_b(1'b0, 1'b1, 1'b0, DE);
        cyc();
        set_d(1'b1, 2'd1, 32'h8000_4000);
        set_b(1'b1, 1'b0, 1'b0, '0);
        push_acc(2'b01, 2'd1, 32'h8000_4000);
        mid();
        check("g_idle_req", axi_rd_req, 1'b1);
        nxt();
        set_d(1'b0, 2'd0, '0);
        set_b(1'b0, 1'b1, 1'b0, DG);
        push_ret(3'b001, DG);
        cyc();
        set_b(1'b0, 1'b0, 1'b0, '0);
        cyc();

        check("acc_q_drained", acc_q.size(), 0);
        check("ret_q_drained", ret_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
